lion_mem_bridge: RTL and testbench

Downstream stage of the Lion core's native memory port (mem_valid / mem_instr / mem_addr / mem_wdata / mem_wstrb / mem_rdata). The bridge converts the core's held-valid, single-outstanding request into a granted, split-response bus transaction. It checks alignment and strobe legality, bounds every access with a watchdog, and returns data with a one-cycle mem_ready pulse plus an error flag. Sits between the core (or its formal wrapper) and the SoC memory/bus fabric.

---
 rtl/lion_mem_pkg.sv | 32 +++
 rtl/lion_mem_bridge_if.sv | 41 ++++
 rtl/lion_mem_watchdog.sv | 31 +++
 rtl/lion_mem_bridge.sv | 154 +++++++++++++++
 tb/tb_lion_mem_bridge.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lion_mem_pkg.sv
// Shared types and helpers for the Lion memory-port bridge.
// Holds the FSM state encoding, request legality check and error-cause codes.
package lion_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Cause codes reserved for a status CSR that will record why mem_err fired.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_STRB    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // A request is legal when word aligned and its strobe pattern is a byte,
    // an aligned halfword or a full word (0 = read).
    function automatic logic strobe_legal(input logic [1:0] addr_lo, input logic [3:0] wstrb);
        logic strb_ok;
        case (wstrb)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF: strb_ok = 1'b1;
            4'h3, 4'hC:                         strb_ok = ~addr_lo[0];
            default:                            strb_ok = 1'b0;
        endcase
        return strb_ok && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/lion_mem_bridge_if.sv
// Signal bundle between the Lion core memory port, the bridge and the SoC bus.
// slave = bridge view, master = core + fabric view.
interface lion_mem_bridge_if;

    // Handshakes: mem_valid is held with all mem_* fields until the one-cycle
    // mem_ready pulse; bus_req is held with all bus_* fields until bus_gnt;
    // bus_rvalid qualifies bus_rdata and is only meaningful after a grant.
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;

    logic        bus_req;
    logic        bus_we;
    logic        bus_instr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_err,
        output bus_req, bus_we, bus_instr, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_err,
        input  bus_req, bus_we, bus_instr, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/lion_mem_watchdog.sv
// Access watchdog: counts cycles while enabled and flags expiry so the bridge
// can terminate a request whose response never arrives.
module lion_mem_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // The count lags the bridge's cycle number by one, so expiring at
    // TIMEOUT-1 lands the error response exactly TIMEOUT cycles after entry.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expire = enable && (count >= LIMIT);

endmodule

// File: rtl/lion_mem_bridge.sv
// Converts the Lion core's held-valid memory request into a request/grant,
// split-response bus transaction with legality checks and a timeout.
module lion_mem_bridge
    import lion_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    lion_mem_bridge_if.slave mif,
    output state_t           dbg_state
);

    state_t      state, state_next;

    logic        mem_ready_q, mem_ready_d;
    logic        mem_err_q,   mem_err_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic        bus_instr_q, bus_instr_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q,    bus_be_d;

    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expire;
    logic        req_legal;

    assign req_legal = strobe_legal(mif.mem_addr[1:0], mif.mem_wstrb);

    lion_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Completion outputs default to zero every cycle so mem_rdata/mem_err can
    // only be non-zero during the single RESP cycle.
    always_comb begin
        state_next  = state;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        mem_rdata_d = '0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_instr_d = bus_instr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;

        case (state)
            ST_IDLE: begin
                if (mif.mem_valid) begin
                    if (!req_legal) begin
                        state_next  = ST_RESP;
                        mem_ready_d = 1'b1;
                        mem_err_d   = 1'b1;
                    end else begin
                        state_next  = ST_REQ;
                        wd_clear    = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = |mif.mem_wstrb;
                        bus_instr_d = mif.mem_instr;
                        bus_addr_d  = {mif.mem_addr[31:2], 2'b00};
                        bus_wdata_d = mif.mem_wdata;
                        bus_be_d    = (|mif.mem_wstrb) ? mif.mem_wstrb : 4'hF;
                    end
                end
            end

            ST_REQ: begin
                wd_enable = 1'b1;
                // A response arriving alongside the grant is a protocol
                // violation; it is ignored simply by not looking at it here.
                if (mif.bus_gnt) begin
                    state_next = ST_WAIT;
                    bus_req_d  = 1'b0;
                end else if (wd_expire) begin
                    state_next  = ST_RESP;
                    bus_req_d   = 1'b0;
                    mem_ready_d = 1'b1;
                    mem_err_d   = 1'b1;
                end
            end

            ST_WAIT: begin
                wd_enable = 1'b1;
                if (mif.bus_rvalid) begin
                    state_next  = ST_RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = bus_we_q ? 32'h0 : mif.bus_rdata;
                end else if (wd_expire) begin
                    state_next  = ST_RESP;
                    mem_ready_d = 1'b1;
                    mem_err_d   = 1'b1;
                end
            end

            ST_RESP: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_instr_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
        end else begin
            state       <= state_next;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_instr_q <= bus_instr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
        end
    end

    assign mif.mem_ready = mem_ready_q;
    assign mif.mem_err   = mem_err_q;
    assign mif.mem_rdata = mem_rdata_q;
    assign mif.bus_req   = bus_req_q;
    assign mif.bus_we    = bus_we_q;
    assign mif.bus_instr = bus_instr_q;
    assign mif.bus_addr  = bus_addr_q;
    assign mif.bus_wdata = bus_wdata_q;
    assign mif.bus_be    = bus_be_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_lion_mem_bridge.sv
// Self-checking bench for lion_mem_bridge: scenario tasks check timing inline,
// a negedge monitor checks every mem_ready response against an expected queue.
module tb_lion_mem_bridge;
    import lion_mem_pkg::*;

    localparam int unsigned TO = 8;

    logic   clock = 1'b0;
    logic   reset = 1'b0;
    state_t dbg_state;

    lion_mem_bridge_if mif ();

    lion_mem_bridge #(
        .TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mif       (mif),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned ready_seen  = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    logic        obs_we, obs_instr, obs_req_at_ready;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;

    // Response monitor: each mem_ready pulse must match the oldest expectation;
    // outside a pulse the data/error outputs must be zero.
    always @(negedge clock) begin
        if (reset) begin
            vectors++;
            if (mif.mem_ready) begin
                ready_seen++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ready: got err=%0b rdata=%08h, required no mem_ready",
                             mif.mem_err, mif.mem_rdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({mif.mem_err, mif.mem_rdata} !== mon_exp) begin
                        miscompares++;
                        $display("FAIL resp: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                                 mif.mem_err, mif.mem_rdata, mon_exp[32], mon_exp[31:0]);
                    end
                end
            end else if ({mif.mem_err, mif.mem_rdata} !== 33'd0) begin
                miscompares++;
                $display("FAIL quiet_outputs: got err=%0b rdata=%08h while mem_ready=0, required 0",
                         mif.mem_err, mif.mem_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Core + fabric driver. Request presented in cycle 0; grant given in the
    // gnt_wait-th cycle bus_req is seen; response rsp_wait cycles after the
    // grant (0 = never). Returns in the cycle after mem_ready (lat=-1 if none).
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr,
                              input int gnt_wait, input int rsp_wait,
                              input logic [31:0] rdata,
                              output int lat, output int req_cycles);
        int since_gnt;
        bit gnt_done;
        bit got;
        since_gnt = 0; gnt_done = 0; got = 0; lat = 0; req_cycles = 0;
        obs_be = '0; obs_we = 0; obs_instr = 0; obs_addr = '0; obs_wdata = '0;
        obs_req_at_ready = 1'b1;
        mif.mem_valid = 1'b1;
        mif.mem_addr  = addr;
        mif.mem_wdata = wdata;
        mif.mem_wstrb = wstrb;
        mif.mem_instr = instr;
        while (!got && lat < 200) begin
            tick();
            lat++;
            mif.bus_gnt    = 1'b0;
            mif.bus_rvalid = 1'b0;
            if (mif.mem_ready) begin
                got = 1;
                obs_req_at_ready = mif.bus_req;
            end else if (mif.bus_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    obs_be = mif.bus_be; obs_we = mif.bus_we; obs_instr = mif.bus_instr;
                    obs_addr = mif.bus_addr; obs_wdata = mif.bus_wdata;
                end
                if (req_cycles == gnt_wait) begin
                    mif.bus_gnt = 1'b1;
                    gnt_done    = 1;
                end
            end else if (gnt_done) begin
                since_gnt++;
                if (since_gnt == rsp_wait) begin
                    mif.bus_rvalid = 1'b1;
                    mif.bus_rdata  = rdata;
                end
            end
        end
        mif.mem_valid = 1'b0;
        if (!got) lat = -1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
        end
        vectors++;
        if ({mif.mem_ready, mif.mem_err, mif.mem_rdata} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_mem_outputs: got ready=%0b err=%0b rdata=%08h, required all 0",
                     mif.mem_ready, mif.mem_err, mif.mem_rdata);
        end
        vectors++;
        if ({mif.bus_req, mif.bus_we, mif.bus_instr, mif.bus_addr, mif.bus_wdata, mif.bus_be} !== 71'd0) begin
            miscompares++;
            $display("FAIL reset_bus_outputs: got req=%0b we=%0b instr=%0b addr=%08h wdata=%08h be=%h, required all 0",
                     mif.bus_req, mif.bus_we, mif.bus_instr, mif.bus_addr, mif.bus_wdata, mif.bus_be);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int lat, reqc;
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        run_access(32'h100, 32'h0, 4'h0, 1'b0, 1, 2, 32'hDEADBEEF, lat, reqc);
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("FAIL read_latency: got %0d, required 4", lat);
        end
        vectors++;
        if ({obs_be, obs_we, obs_addr} !== {4'hF, 1'b0, 32'h100}) begin
            miscompares++;
            $display("FAIL read_bus_fields: got be=%h we=%0b addr=%08h, required be=f we=0 addr=00000100",
                     obs_be, obs_we, obs_addr);
        end
        vectors++;
        if (reqc != 1) begin
            miscompares++;
            $display("FAIL read_req_cycles: got %0d, required 1", reqc);
        end
    endtask

    task automatic test_write();
        int lat, reqc;
        exp_q.push_back({1'b0, 32'h0});
        run_access(32'h204, 32'h12345678, 4'hC, 1'b0, 5, 2, 32'hFFFF0000, lat, reqc);
        vectors++;
        if (reqc != 5) begin
            miscompares++;
            $display("FAIL write_req_held: got %0d cycles, required 5", reqc);
        end
        vectors++;
        if (lat != 8) begin
            miscompares++;
            $display("FAIL write_latency: got %0d, required 8", lat);
        end
        vectors++;
        if ({obs_be, obs_we, obs_addr, obs_wdata} !== {4'hC, 1'b1, 32'h204, 32'h12345678}) begin
            miscompares++;
            $display("FAIL write_bus_fields: got be=%h we=%0b addr=%08h wdata=%08h, required be=c we=1 addr=00000204 wdata=12345678",
                     obs_be, obs_we, obs_addr, obs_wdata);
        end
    endtask

    task automatic test_illegal();
        int lat, reqc;
        logic [31:0] addrs [3];
        logic [3:0]  strbs [3];
        addrs[0] = 32'h102; strbs[0] = 4'h0;
        addrs[1] = 32'h200; strbs[1] = 4'h5;
        addrs[2] = 32'h300; strbs[2] = 4'h6;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b1, 32'h0});
            run_access(addrs[i], 32'hA5A5A5A5, strbs[i], 1'b0, 1, 1, 32'h11111111, lat, reqc);
            vectors++;
            if (lat != 1 || reqc != 0) begin
                miscompares++;
                $display("FAIL illegal_%0d: got latency=%0d req_cycles=%0d, required latency=1 req_cycles=0",
                         i, lat, reqc);
            end
        end
    endtask

    task automatic test_timeout();
        int lat, reqc;
        exp_q.push_back({1'b1, 32'h0});
        run_access(32'h40, 32'h0, 4'h0, 1'b0, 1, 0, 32'h0, lat, reqc);
        vectors++;
        if (lat != int'(TO) + 1) begin
            miscompares++;
            $display("FAIL timeout_wait_latency: got %0d, required %0d", lat, TO + 1);
        end
        mif.bus_rvalid = 1'b1;
        mif.bus_rdata  = 32'hBAD0BAD0;
        tick();
        mif.bus_rvalid = 1'b0;
        tick();
        exp_q.push_back({1'b0, 32'h55AA55AA});
        run_access(32'h44, 32'h0, 4'h0, 1'b0, 1, 1, 32'h55AA55AA, lat, reqc);
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL after_timeout_latency: got %0d, required 3", lat);
        end
        exp_q.push_back({1'b1, 32'h0});
        run_access(32'h48, 32'h0, 4'h0, 1'b0, 1000, 1, 32'h0, lat, reqc);
        vectors++;
        if (lat != int'(TO) + 1 || reqc != int'(TO) || obs_req_at_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_req: got latency=%0d req_cycles=%0d bus_req=%0b, required latency=%0d req_cycles=%0d bus_req=0",
                     lat, reqc, obs_req_at_ready, TO + 1, TO);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned seen_before;
        seen_before = ready_seen;
        mif.mem_valid = 1'b1;
        mif.mem_addr  = 32'h80;
        mif.mem_wstrb = 4'h0;
        mif.mem_instr = 1'b0;
        tick();
        mif.bus_gnt = 1'b1;
        tick();
        mif.bus_gnt = 1'b0;
        reset = 1'b0;
        tick();
        vectors++;
        if (dbg_state !== ST_IDLE || mif.bus_req !== 1'b0 || mif.mem_ready !== 1'b0 || mif.bus_be !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got state=%0d bus_req=%0b mem_ready=%0b be=%h, required 0 0 0 0",
                     dbg_state, mif.bus_req, mif.mem_ready, mif.bus_be);
        end
        mif.mem_valid = 1'b0;
        reset = 1'b1;
        tick();
        mif.bus_rvalid = 1'b1;
        mif.bus_rdata  = 32'h1234;
        tick();
        mif.bus_rvalid = 1'b0;
        repeat (3) tick();
        vectors++;
        if (ready_seen != seen_before || dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL stray_rvalid: got %0d ready pulses state=%0d, required 0 pulses state=0",
                     ready_seen - seen_before, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        int lat, reqc;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            exp_q.push_back({1'b0, 32'hC0DE0000 | a});
            run_access(a, 32'h0, 4'h0, 1'b1, 1, 1, 32'hC0DE0000 | a, lat, reqc);
            vectors++;
            if (lat != 3 || obs_instr !== 1'b1 || obs_addr !== a) begin
                miscompares++;
                $display("FAIL fetch_%0d: got latency=%0d instr=%0b addr=%08h, required 3 1 %08h",
                         i, lat, obs_instr, obs_addr, a);
            end
        end
    endtask

    task automatic test_random();
        int lat, reqc, gw, rw, exp_lat;
        logic [31:0] addr, rd;
        logic [3:0]  s;
        bit legal;
        for (int i = 0; i < 10; i++) begin
            addr = {$urandom_range(0, 255) << 4} | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            s  = 4'($urandom_range(0, 15));
            gw = $urandom_range(1, 3);
            rw = $urandom_range(1, 3);
            rd = $urandom;
            legal = (addr[1:0] == 2'b00) &&
                    (s == 4'h0 || s == 4'h1 || s == 4'h2 || s == 4'h4 ||
                     s == 4'h8 || s == 4'h3 || s == 4'hC || s == 4'hF);
            exp_lat = legal ? gw + rw + 1 : 1;
            if (!legal)          exp_q.push_back({1'b1, 32'h0});
            else if (s != 4'h0)  exp_q.push_back({1'b0, 32'h0});
            else                 exp_q.push_back({1'b0, rd});
            run_access(addr, $urandom, s, 1'b0, gw, rw, rd, lat, reqc);
            vectors++;
            if (lat != exp_lat || (legal && obs_be !== ((s == 4'h0) ? 4'hF : s))) begin
                miscompares++;
                $display("FAIL random_%0d: addr=%08h strb=%h got latency=%0d be=%h, required latency=%0d",
                         i, addr, s, lat, obs_be, exp_lat);
            end
        end
    endtask

    initial begin
        mif.mem_valid  = 1'b0;
        mif.mem_instr  = 1'b0;
        mif.mem_addr   = '0;
        mif.mem_wdata  = '0;
        mif.mem_wstrb  = '0;
        mif.bus_gnt    = 1'b0;
        mif.bus_rvalid = 1'b0;
        mif.bus_rdata  = '0;

        test_reset();
        test_read();
        test_write();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) tick();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_responses: got %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
